ic_receiver: RTL and testbench

- Receive-side IC deframer for the lpGBT internal-control channel, clocked by clk_40.
- Takes the 2-bit IC stream returned from the lpGBT. Finds 0x7E frame delimiters at either bit phase and deserializes the bytes between them.
- Presents the bytes as a framed byte stream with frame length and parity status to the slow-control readout logic.
- Framing has no bit stuffing, matching the team's IC transmit side; bits are MSB first, ic[1] before ic[0].

---
 rtl/ic_pkg.sv | 13 +
 rtl/ic_flag_aligner.sv | 69 ++++++
 rtl/ic_receiver.sv | 159 +++++++++++++++
 tb/tb_ic_receiver.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ic_pkg.sv
// Shared constants for the lpGBT IC receive path: delimiter value, bits per
// clk_40 cycle and the deframer state encodings.
package ic_pkg;

    localparam logic [7:0] IC_FLAG           = 8'h7E;
    localparam int         IC_BITS_PER_CYCLE = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HUNT = 2'd1;
    localparam logic [1:0] ST_OPEN = 2'd2;
    localparam logic [1:0] ST_RECV = 2'd3;

endpackage

// File: rtl/ic_flag_aligner.sv
// Shift history, dual-phase 0x7E search, phase lock and byte tick for the IC stream.
// byte_o/is_flag_o are combinational from registers; no backpressure (stream cannot stall).
module ic_flag_aligner
    import ic_pkg::*;
(
    input  logic       clk_40,
    input  logic       rst,
    input  logic [1:0] ic_i,
    input  logic       unlock_i,
    output logic       flag_found_o,
    output logic       byte_strobe_o,
    output logic [7:0] byte_o,
    output logic       is_flag_o,
    output logic       locked_o,
    output logic       phase_o
);

    logic [7+IC_BITS_PER_CYCLE:0] sr_q, sr_d;
    logic                         locked_q, locked_d;
    logic                         phase_q, phase_d;
    logic [1:0]                   tick_q, tick_d;
    logic                         hit0, hit1;
    logic                         sr_msb_unused;

    assign sr_msb_unused = sr_q[9];

    assign hit0 = (sr_q[7:0] == IC_FLAG);
    assign hit1 = (sr_q[8:1] == IC_FLAG);

    assign flag_found_o  = !locked_q && (hit0 || hit1);
    assign byte_o        = phase_q ? sr_q[8:1] : sr_q[7:0];
    assign byte_strobe_o = locked_q && (tick_q == 2'd3);
    assign is_flag_o     = (byte_o == IC_FLAG);
    assign locked_o      = locked_q;
    assign phase_o       = phase_q;

    // While hunting, the delimiter just found fixes the byte grid: the tick
    // restarts so the next full byte lands exactly four cycles later.
    always_comb begin
        sr_d     = {sr_q[7:0], ic_i};
        locked_d = locked_q;
        phase_d  = phase_q;
        tick_d   = tick_q + 2'd1;
        if (!locked_q) begin
            if (hit0 || hit1) begin
                locked_d = 1'b1;
                phase_d  = !hit0;
                tick_d   = 2'd0;
            end
        end else if (unlock_i) begin
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk_40 or posedge rst) begin
        if (rst) begin
            sr_q     <= '0;
            locked_q <= 1'b0;
            phase_q  <= 1'b0;
            tick_q   <= 2'd0;
        end else begin
            sr_q     <= sr_d;
            locked_q <= locked_d;
            phase_q  <= phase_d;
            tick_q   <= tick_d;
        end
    end

endmodule

// File: rtl/ic_receiver.sv
// lpGBT IC receive deframer: delimiter-framed bytes out with length/parity status.
// A byte is emitted 1 cycle after the following byte boundary; no backpressure.
module ic_receiver
    import ic_pkg::*;
#(
    parameter int MAX_BYTES    = 32,
    parameter int MIN_BYTES    = 3,
    parameter int PARITY_START = 2
) (
    input  logic       clk_40,
    input  logic       rst,
    input  logic [1:0] ic,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_sop,
    output logic       rx_eop,
    output logic       frame_done,
    output logic [8:0] frame_len,
    output logic       parity_err,
    output logic       len_err,
    output logic       locked,
    output logic       phase
);

    logic       flag_found, byte_strobe, is_flag, unlock;
    logic [7:0] rx_byte;

    logic [1:0] state_q, state_d;
    logic [8:0] count_q, count_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       sop_q, sop_d;
    logic       eop_q, eop_d;
    logic       done_q, done_d;
    logic [8:0] len_q, len_d;
    logic       perr_q, perr_d;
    logic       lerr_q, lerr_d;

    ic_flag_aligner u_aligner (
        .clk_40        (clk_40),
        .rst           (rst),
        .ic_i          (ic),
        .unlock_i      (unlock),
        .flag_found_o  (flag_found),
        .byte_strobe_o (byte_strobe),
        .byte_o        (rx_byte),
        .is_flag_o     (is_flag),
        .locked_o      (locked),
        .phase_o       (phase)
    );

    // Each byte is held until the next boundary reveals whether it was the last.
    // acc covers bytes already known not to be last, so at close it is the
    // parity the held (last) byte must match.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hold_d  = hold_q;
        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        done_d  = 1'b0;
        len_d   = len_q;
        perr_d  = perr_q;
        lerr_d  = lerr_q;
        unlock  = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_HUNT;
            ST_HUNT: begin
                if (flag_found) begin
                    state_d = ST_OPEN;
                end
            end
            ST_OPEN: begin
                if (byte_strobe && !is_flag) begin
                    hold_d  = rx_byte;
                    count_d = 9'd1;
                    acc_d   = 8'h00;
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                if (byte_strobe) begin
                    if (is_flag) begin
                        data_d  = hold_q;
                        valid_d = 1'b1;
                        sop_d   = (count_q == 9'd1);
                        eop_d   = 1'b1;
                        done_d  = 1'b1;
                        len_d   = count_q;
                        perr_d  = (acc_q != hold_q);
                        lerr_d  = (count_q < 9'(MIN_BYTES));
                        state_d = ST_OPEN;
                    end else if (count_q == 9'(MAX_BYTES)) begin
                        done_d  = 1'b1;
                        len_d   = 9'(MAX_BYTES);
                        perr_d  = 1'b0;
                        lerr_d  = 1'b1;
                        unlock  = 1'b1;
                        state_d = ST_HUNT;
                    end else begin
                        data_d  = hold_q;
                        valid_d = 1'b1;
                        sop_d   = (count_q == 9'd1);
                        if (count_q >= 9'(PARITY_START + 1)) begin
                            acc_d = acc_q ^ hold_q;
                        end
                        hold_d  = rx_byte;
                        count_d = count_q + 9'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_40 or posedge rst) begin
        if (rst) begin
            state_q <= ST_HUNT;
            count_q <= '0;
            hold_q  <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            done_q  <= 1'b0;
            len_q   <= '0;
            perr_q  <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            done_q  <= done_d;
            len_q   <= len_d;
            perr_q  <= perr_d;
            lerr_q  <= lerr_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign rx_sop     = sop_q;
    assign rx_eop     = eop_q;
    assign frame_done = done_q;
    assign frame_len  = len_q;
    assign parity_err = perr_q;
    assign len_err    = lerr_q;

endmodule

// File: tb/tb_ic_receiver.sv
// Bench for ic_receiver: directed frame table, hand-written corner sequences and
// random streams checked against a bit-level reference parser.
module tb_ic_receiver;

    localparam int MAXB   = 32;
    localparam int MINB   = 3;
    localparam int PSTART = 2;

    logic       clk_40 = 1'b0;
    logic       rst    = 1'b0;
    logic [1:0] ic     = 2'b11;
    logic [7:0] rx_data;
    logic       rx_valid, rx_sop, rx_eop, frame_done;
    logic [8:0] frame_len;
    logic       parity_err, len_err, locked, phase;

    ic_receiver #(
        .MAX_BYTES    (MAXB),
        .MIN_BYTES    (MINB),
        .PARITY_START (PSTART)
    ) dut (
        .clk_40     (clk_40),
        .rst        (rst),
        .ic         (ic),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_sop     (rx_sop),
        .rx_eop     (rx_eop),
        .frame_done (frame_done),
        .frame_len  (frame_len),
        .parity_err (parity_err),
        .len_err    (len_err),
        .locked     (locked),
        .phase      (phase)
    );

    always #5 clk_40 = ~clk_40;

    typedef struct {
        int         step;
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } byte_ev_t;

    typedef struct {
        int   step;
        int   len;
        logic perr;
        logic lerr;
    } done_ev_t;

    typedef struct {
        int   lead;
        int   kind;   // 0 clean A, 1 corrupt parity, 2 short, 3 overflow
        int   nb;
        int   len;
        logic perr;
        logic lerr;
        logic ph;
        logic lk;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    string      ctx = "init";
    bit         sbits[$];
    logic [7:0] pay[$];
    byte_ev_t   got_b[$], exp_b[$];
    done_ev_t   got_d[$], exp_d[$];
    logic       exp_locked, exp_phase;
    logic [7:0] frame_a[8] = '{8'hE0, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'hAB, 8'hAA};
    vec_t       vecs[5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", ctx, name, got, exp);
        end
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) sbits.push_back(b[i]);
    endtask

    task automatic add_ones(input int n);
        for (int i = 0; i < n; i++) sbits.push_back(1'b1);
    endtask

    function automatic logic [7:0] get_byte(input int at);
        logic [7:0] r = 8'h00;
        for (int j = 0; j < 8; j++) r = {r[6:0], sbits[at+j]};
        return r;
    endfunction

    // Reference: parse the serial bit list directly. An event caused by the byte
    // whose last bit sits at index e is seen at bench step e/2+1.
    task automatic ref_model();
        int         n = sbits.size();
        int         nslots = n / 2;
        bit         hunting = 1'b1;
        int         hunt_from = 7;
        int         pos = 0;
        int         st, k;
        logic [7:0] cur[$];
        logic [7:0] b, acc;
        exp_b.delete();
        exp_d.delete();
        exp_locked = 1'b0;
        exp_phase  = 1'b0;
        while (1) begin
            if (hunting) begin
                k = hunt_from;
                while (k < n && get_byte(k - 7) != 8'h7E) k++;
                if (k >= n || k / 2 + 1 >= nslots) break;
                hunting    = 1'b0;
                exp_locked = 1'b1;
                exp_phase  = (k % 2 == 0);
                pos        = k + 1;
                cur.delete();
            end
            if (pos + 7 >= n) break;
            b   = get_byte(pos);
            st  = (pos + 7) / 2 + 1;
            pos = pos + 8;
            if (st >= nslots) break;
            if (b == 8'h7E) begin
                if (cur.size() > 0) begin
                    acc = 8'h00;
                    for (int i = PSTART; i <= cur.size() - 2; i++) acc ^= cur[i];
                    exp_b.push_back('{st, cur[cur.size()-1], cur.size() == 1, 1'b1});
                    exp_d.push_back('{st, cur.size(), acc != cur[cur.size()-1], cur.size() < MINB});
                    cur.delete();
                end
            end else if (cur.size() == MAXB) begin
                exp_d.push_back('{st, MAXB, 1'b0, 1'b1});
                exp_locked = 1'b0;
                hunting    = 1'b1;
                hunt_from  = 2 * st;
                cur.delete();
            end else begin
                if (cur.size() > 0) exp_b.push_back('{st, cur[cur.size()-1], cur.size() == 1, 1'b0});
                cur.push_back(b);
            end
        end
    endtask

    task automatic run_stream(input int pad_slots);
        add_ones(2 * pad_slots + (sbits.size() % 2));
        got_b.delete();
        got_d.delete();
        rst = 1'b1;
        ic  = 2'b11;
        repeat (2) @(negedge clk_40);
        rst = 1'b0;
        for (int s = 0; s < sbits.size() / 2; s++) begin
            ic = {sbits[2*s], sbits[2*s+1]};
            @(posedge clk_40);
            @(negedge clk_40);
            if (rx_valid) got_b.push_back('{s, rx_data, rx_sop, rx_eop});
            if (frame_done) got_d.push_back('{s, int'(frame_len), parity_err, len_err});
        end
        ref_model();
        check("byte_count", got_b.size(), exp_b.size());
        for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) begin
            check("byte_step", got_b[i].step, exp_b[i].step);
            check("byte_data", got_b[i].data, exp_b[i].data);
            check("byte_sop_eop", {got_b[i].sop, got_b[i].eop}, {exp_b[i].sop, exp_b[i].eop});
        end
        check("done_count", got_d.size(), exp_d.size());
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            check("done_step", got_d[i].step, exp_d[i].step);
            check("done_len", got_d[i].len, exp_d[i].len);
            check("done_perr_lerr", {got_d[i].perr, got_d[i].lerr}, {exp_d[i].perr, exp_d[i].lerr});
        end
        check("locked_end", locked, exp_locked);
        check("phase_end", phase, exp_phase);
    endtask

    task automatic build_frame_a();
        sbits.delete();
        add_ones(8);
        add_byte(8'h7E);
        for (int i = 0; i < 8; i++) add_byte(frame_a[i]);
        add_byte(8'h7E);
    endtask

    initial begin
        int         nfr, len, sops;
        logic [7:0] b, acc;

        vecs[0] = '{8, 0, 8,  8,  1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{9, 0, 8,  8,  1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{8, 1, 8,  8,  1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8, 2, 1,  1,  1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8, 3, 31, 32, 1'b0, 1'b1, 1'b0, 1'b0};

        ctx = "reset";
        #1 rst = 1'b1;
        #1;
        check("outputs_in_reset",
              {rx_data, rx_valid, rx_sop, rx_eop, frame_done, frame_len, parity_err, len_err, locked, phase}, 0);

        for (int v = 0; v < 5; v++) begin
            ctx = $sformatf("table%0d", v);
            sbits.delete();
            pay.delete();
            add_ones(vecs[v].lead);
            add_byte(8'h7E);
            case (vecs[v].kind)
                0: for (int i = 0; i < 8; i++) pay.push_back(frame_a[i]);
                1: begin
                    for (int i = 0; i < 7; i++) pay.push_back(frame_a[i]);
                    pay.push_back(8'h55);
                end
                2: pay.push_back(8'hE0);
                default: for (int i = 0; i < 33; i++) pay.push_back(8'h55);
            endcase
            foreach (pay[i]) add_byte(pay[i]);
            if (vecs[v].kind != 3) add_byte(8'h7E);
            run_stream(8);
            check("tbl_nbytes", got_b.size(), vecs[v].nb);
            check("tbl_done_count", got_d.size(), 1);
            if (got_d.size() > 0) begin
                check("tbl_len", got_d[0].len, vecs[v].len);
                check("tbl_perr", got_d[0].perr, vecs[v].perr);
                check("tbl_lerr", got_d[0].lerr, vecs[v].lerr);
            end
            check("tbl_locked", locked, vecs[v].lk);
            check("tbl_phase", phase, vecs[v].ph);
            if (got_b.size() > 0) begin
                check("tbl_sop_first", got_b[0].sop, 1'b1);
                check("tbl_eop_last", got_b[got_b.size()-1].eop, vecs[v].kind != 3);
            end
            for (int i = 0; i < got_b.size() && i < pay.size(); i++)
                check("tbl_data", got_b[i].data, pay[i]);
        end

        ctx = "back_to_back";
        sbits.delete();
        add_ones(8);
        add_byte(8'h7E);
        for (int i = 0; i < 8; i++) add_byte(frame_a[i]);
        add_byte(8'h7E);
        add_byte(8'h10); add_byte(8'h20); add_byte(8'h30); add_byte(8'h40);
        repeat (3) add_byte(8'h7E);
        for (int i = 0; i < 8; i++) add_byte(frame_a[i]);
        add_byte(8'h7E);
        run_stream(8);
        sops = 0;
        foreach (got_b[i]) if (got_b[i].sop) sops++;
        check("b2b_done_count", got_d.size(), 3);
        check("b2b_bytes", got_b.size(), 20);
        check("b2b_sop_count", sops, 3);

        ctx = "reset_mid_frame";
        sbits.delete();
        add_ones(8);
        add_byte(8'h7E);
        add_byte(8'hE0); add_byte(8'h01); add_byte(8'h01);
        run_stream(1);
        check("partial_bytes", got_b.size(), 2);
        #3 rst = 1'b1;
        #1;
        check("outputs_after_async_reset",
              {rx_data, rx_valid, rx_sop, rx_eop, frame_done, frame_len, parity_err, len_err, locked, phase}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_40);
            check("no_done_in_reset", frame_done, 1'b0);
        end
        ctx = "after_reset";
        build_frame_a();
        run_stream(8);
        check("fresh_done_count", got_d.size(), 1);
        check("fresh_bytes", got_b.size(), 8);

        for (int it = 0; it < 25; it++) begin
            ctx = $sformatf("random%0d", it);
            sbits.delete();
            add_ones(7 + int'($urandom % 6));
            add_byte(8'h7E);
            nfr = 1 + int'($urandom % 3);
            for (int f = 0; f < nfr; f++) begin
                len = 1 + int'($urandom % 34);
                acc = 8'h00;
                for (int i = 0; i < len - 1; i++) begin
                    do b = 8'($urandom); while (b == 8'h7E);
                    if (i >= PSTART) acc ^= b;
                    add_byte(b);
                end
                do b = 8'($urandom); while (b == 8'h7E);
                if ($urandom % 2 == 1) b = acc;
                add_byte(b);
                repeat (1 + int'($urandom % 2)) add_byte(8'h7E);
            end
            run_stream(8);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
